workout_sequencer: RTL and testbench

Interval scheduler for the fitness timer. It sequences the workout through IDLE, WORK, REST and DONE phases and counts exercises and seconds. It drives the buzzer on phase changes and during the final-second warnings. It sits between the button debouncers, the 1 Hz tick generator and the exercise calculator on one side, and the 7-segment/LCD display drivers on the other.

---
 rtl/workout_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_workout_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/workout_sequencer.sv
// Interval scheduler for the fitness timer: walks IDLE/WORK/REST/DONE, counts
// exercises and seconds, and times the buzzer for phase starts and final-second warnings.
module workout_sequencer #(
  parameter int BEEP_LONG_CYCLES  = 20000000,
  parameter int BEEP_SHORT_CYCLES = 4000000,
  parameter int DONE_HOLD_S       = 10
) (
  input  logic       i_clk_40MHz,
  input  logic       i_system_reset,
  input  logic       i_tick_1hz,
  input  logic       i_start_pulse,
  input  logic       i_skip_pulse,
  input  logic [8:0] i_total_exercises,
  input  logic [7:0] i_work_seconds,
  input  logic [7:0] i_rest_seconds,
  output logic [1:0] o_workout_state,
  output logic [8:0] o_current_exercise_num,
  output logic [7:0] o_countdown_seconds,
  output logic       o_buzzer,
  output logic       o_phase_change
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WORK = 2'b01,
    ST_REST = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam int BEEP_MAX = (BEEP_LONG_CYCLES > BEEP_SHORT_CYCLES) ?
                            BEEP_LONG_CYCLES : BEEP_SHORT_CYCLES;
  localparam int BEEP_W   = $clog2(BEEP_MAX + 1);

  localparam logic [BEEP_W-1:0] LONG_LEN  = BEEP_W'(BEEP_LONG_CYCLES);
  localparam logic [BEEP_W-1:0] SHORT_LEN = BEEP_W'(BEEP_SHORT_CYCLES);
  localparam logic [7:0]        DONE_HOLD = 8'(DONE_HOLD_S);

  logic [1:0]        r_rst_sync;
  logic              w_rst;

  state_t            r_state;
  logic [8:0]        r_exercise;
  logic [7:0]        r_countdown;
  logic [BEEP_W-1:0] r_beep_cnt;
  logic              r_phase_change;
  logic [8:0]        r_cfg_total;
  logic [7:0]        r_cfg_work;
  logic [7:0]        r_cfg_rest;

  state_t            w_state_nxt;
  logic [8:0]        w_exercise_nxt;
  logic [7:0]        w_countdown_nxt;
  logic              w_beep_load;
  logic [BEEP_W-1:0] w_beep_len;
  logic              w_latch_cfg;
  logic              w_start_ok;
  logic              w_phase_end;

  // Reset asserts at once but releases only on a clock edge, two flops later.
  always_ff @(posedge i_clk_40MHz or posedge i_system_reset) begin
    if (i_system_reset) begin
      r_rst_sync <= 2'b11;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b0};
    end
  end

  assign w_rst = r_rst_sync[1];

  always_ff @(posedge i_clk_40MHz or posedge w_rst) begin
    if (w_rst) begin
      r_state        <= ST_IDLE;
      r_exercise     <= '0;
      r_countdown    <= '0;
      r_beep_cnt     <= '0;
      r_phase_change <= 1'b0;
      r_cfg_total    <= '0;
      r_cfg_work     <= '0;
      r_cfg_rest     <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_exercise     <= w_exercise_nxt;
      r_countdown    <= w_countdown_nxt;
      r_phase_change <= (w_state_nxt != r_state);
      if (w_latch_cfg) begin
        r_cfg_total <= i_total_exercises;
        r_cfg_work  <= i_work_seconds;
        r_cfg_rest  <= i_rest_seconds;
      end
      if (w_beep_load) begin
        r_beep_cnt <= w_beep_len;
      end else if (r_beep_cnt != '0) begin
        r_beep_cnt <= r_beep_cnt - 1'b1;
      end
    end
  end

  assign w_start_ok  = i_start_pulse && (i_total_exercises != '0) && (i_work_seconds != '0);
  assign w_phase_end = i_skip_pulse || (i_tick_1hz && (r_countdown == 8'd1));

  // Skip is checked before tick everywhere, so a coincident tick is simply dropped.
  always_comb begin
    w_state_nxt     = r_state;
    w_exercise_nxt  = r_exercise;
    w_countdown_nxt = r_countdown;
    w_beep_load     = 1'b0;
    w_beep_len      = SHORT_LEN;
    w_latch_cfg     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_latch_cfg     = 1'b1;
          w_state_nxt     = ST_WORK;
          w_exercise_nxt  = 9'd1;
          w_countdown_nxt = i_work_seconds;
          w_beep_load     = 1'b1;
          w_beep_len      = LONG_LEN;
        end
      end

      ST_WORK: begin
        if (w_phase_end) begin
          w_beep_load = 1'b1;
          if (r_exercise == r_cfg_total) begin
            w_state_nxt     = ST_DONE;
            w_countdown_nxt = DONE_HOLD;
            w_beep_len      = LONG_LEN;
          end else if (r_cfg_rest == '0) begin
            w_state_nxt     = ST_WORK;
            w_exercise_nxt  = r_exercise + 9'd1;
            w_countdown_nxt = r_cfg_work;
            w_beep_len      = LONG_LEN;
          end else begin
            w_state_nxt     = ST_REST;
            w_countdown_nxt = r_cfg_rest;
            w_beep_len      = SHORT_LEN;
          end
        end else if (i_tick_1hz) begin
          w_countdown_nxt = r_countdown - 8'd1;
          if (r_countdown <= 8'd4) begin
            w_beep_load = 1'b1;
            w_beep_len  = SHORT_LEN;
          end
        end
      end

      ST_REST: begin
        if (w_phase_end) begin
          w_state_nxt     = ST_WORK;
          w_exercise_nxt  = r_exercise + 9'd1;
          w_countdown_nxt = r_cfg_work;
          w_beep_load     = 1'b1;
          w_beep_len      = LONG_LEN;
        end else if (i_tick_1hz) begin
          w_countdown_nxt = r_countdown - 8'd1;
        end
      end

      ST_DONE: begin
        if (i_start_pulse || (i_tick_1hz && (r_countdown == 8'd1))) begin
          w_state_nxt     = ST_IDLE;
          w_exercise_nxt  = '0;
          w_countdown_nxt = '0;
        end else if (i_tick_1hz && (r_countdown > 8'd1)) begin
          w_countdown_nxt = r_countdown - 8'd1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    o_workout_state        = r_state;
    o_current_exercise_num = r_exercise;
    o_countdown_seconds    = r_countdown;
    o_buzzer               = (r_beep_cnt != '0);
    o_phase_change         = r_phase_change;
  end

endmodule

// File: tb/tb_workout_sequencer.sv
// Directed, table-driven bench for workout_sequencer with short beeps and a 2 s DONE hold
// so full workouts fit in a few hundred cycles.
module tb_workout_sequencer;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       start;
  logic       skip;
  logic [8:0] total;
  logic [7:0] work;
  logic [7:0] rest;
  logic [1:0] oState;
  logic [8:0] oEx;
  logic [7:0] oCd;
  logic       oBuzz;
  logic       oPc;

  int vectorsApplied = 0;
  int miscompares    = 0;

  int cfgTotal = 0;
  int cfgWork  = 0;
  int cfgRest  = 0;

  typedef struct {
    logic       tick;
    logic       start;
    logic       skip;
    logic [8:0] total;
    logic [7:0] work;
    logic [7:0] rest;
    logic [1:0] eState;
    logic [8:0] eEx;
    logic [7:0] eCd;
    logic       eBuzz;
    logic       ePc;
  } vec_t;

  vec_t vecs[$];

  workout_sequencer #(
    .BEEP_LONG_CYCLES (8),
    .BEEP_SHORT_CYCLES(3),
    .DONE_HOLD_S      (2)
  ) dut (
    .i_clk_40MHz           (clk),
    .i_system_reset        (rst),
    .i_tick_1hz            (tick),
    .i_start_pulse         (start),
    .i_skip_pulse          (skip),
    .i_total_exercises     (total),
    .i_work_seconds        (work),
    .i_rest_seconds        (rest),
    .o_workout_state       (oState),
    .o_current_exercise_num(oEx),
    .o_countdown_seconds   (oCd),
    .o_buzzer              (oBuzz),
    .o_phase_change        (oPc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void addVec(input int tk, input int st, input int sk,
                                 input int es, input int ex, input int cd,
                                 input int bz, input int pc);
    vec_t v;
    v.tick   = 1'(tk);
    v.start  = 1'(st);
    v.skip   = 1'(sk);
    v.total  = 9'(cfgTotal);
    v.work   = 8'(cfgWork);
    v.rest   = 8'(cfgRest);
    v.eState = 2'(es);
    v.eEx    = 9'(ex);
    v.eCd    = 8'(cd);
    v.eBuzz  = 1'(bz);
    v.ePc    = 1'(pc);
    vecs.push_back(v);
  endfunction

  // Quiet cycles while a beep drains: nHigh cycles with buzzer on, then one with it off.
  function automatic void addDrain(input int es, input int ex, input int cd, input int nHigh);
    for (int k = 0; k < nHigh; k++) addVec(0, 0, 0, es, ex, cd, 1, 0);
    addVec(0, 0, 0, es, ex, cd, 0, 0);
  endfunction

  task automatic checkOutput(input string name, input logic [1:0] es, input logic [8:0] ex,
                             input logic [7:0] cd, input logic bz, input logic pc);
    vectorsApplied++;
    if ({oState, oEx, oCd, oBuzz, oPc} !== {es, ex, cd, bz, pc}) begin
      miscompares++;
      $display("[TB] FAIL %s: got state=%0d ex=%0d cd=%0d buzz=%0d pc=%0d, expected state=%0d ex=%0d cd=%0d buzz=%0d pc=%0d",
               name, oState, oEx, oCd, oBuzz, oPc, es, ex, cd, bz, pc);
    end
  endtask

  task automatic applyStimulus(input string name, input vec_t v);
    @(negedge clk);
    tick  = v.tick;
    start = v.start;
    skip  = v.skip;
    total = v.total;
    work  = v.work;
    rest  = v.rest;
    @(posedge clk);
    #1;
    checkOutput(name, v.eState, v.eEx, v.eCd, v.eBuzz, v.ePc);
  endtask

  task automatic applyIdle(input string name, input int es, input int ex, input int cd,
                           input int bz, input int pc);
    vec_t v;
    v = '{tick: 1'b0, start: 1'b0, skip: 1'b0, total: total, work: work, rest: rest,
          eState: 2'(es), eEx: 9'(ex), eCd: 8'(cd), eBuzz: 1'(bz), ePc: 1'(pc)};
    applyStimulus(name, v);
  endtask

  initial begin
    vec_t hv;

    // Rejected starts: zero exercises, then zero work time.
    cfgTotal = 0; cfgWork = 5; cfgRest = 3;
    addVec(0, 1, 0, 0, 0, 0, 0, 0);
    cfgTotal = 5; cfgWork = 0;
    addVec(0, 1, 0, 0, 0, 0, 0, 0);

    // Full run on ticks only: 2 exercises, 5 s work, 3 s rest.
    cfgTotal = 2; cfgWork = 5; cfgRest = 3;
    addVec(0, 1, 0, 1, 1, 5, 1, 1);
    addDrain(1, 1, 5, 7);
    addVec(1, 0, 0, 1, 1, 4, 0, 0);
    addVec(1, 0, 0, 1, 1, 3, 1, 0);
    addVec(0, 0, 0, 1, 1, 3, 1, 0);
    addVec(1, 0, 0, 1, 1, 2, 1, 0);
    addVec(1, 0, 0, 1, 1, 1, 1, 0);
    addDrain(1, 1, 1, 2);
    addVec(1, 0, 0, 2, 1, 3, 1, 1);
    addDrain(2, 1, 3, 2);
    addVec(1, 0, 0, 2, 1, 2, 0, 0);
    addVec(1, 0, 0, 2, 1, 1, 0, 0);
    addVec(1, 0, 0, 1, 2, 5, 1, 1);
    addDrain(1, 2, 5, 7);
    addVec(1, 0, 0, 1, 2, 4, 0, 0);
    addVec(1, 0, 0, 1, 2, 3, 1, 0);
    addVec(1, 0, 0, 1, 2, 2, 1, 0);
    addVec(1, 0, 0, 1, 2, 1, 1, 0);
    addVec(1, 0, 0, 3, 2, 2, 1, 1);
    addVec(1, 0, 0, 3, 2, 1, 1, 0);
    addVec(1, 0, 0, 0, 0, 0, 1, 1);
    addDrain(0, 0, 0, 5);

    // Skips, skip+tick collision, ignored start in WORK, ignored skip in DONE, start exits DONE.
    addVec(0, 1, 0, 1, 1, 5, 1, 1);
    addVec(1, 0, 0, 1, 1, 4, 1, 0);
    addVec(1, 0, 1, 2, 1, 3, 1, 1);
    addVec(0, 0, 1, 1, 2, 5, 1, 1);
    addVec(0, 1, 0, 1, 2, 5, 1, 0);
    addVec(0, 0, 1, 3, 2, 2, 1, 1);
    addVec(0, 0, 1, 3, 2, 2, 1, 0);
    addVec(0, 1, 0, 0, 0, 0, 1, 1);
    addDrain(0, 0, 0, 5);

    // Zero rest: start+skip together (start wins), then back-to-back skips straight to DONE.
    cfgTotal = 3; cfgWork = 5; cfgRest = 0;
    addVec(0, 1, 1, 1, 1, 5, 1, 1);
    addVec(0, 0, 1, 1, 2, 5, 1, 0);
    addVec(0, 0, 1, 1, 3, 5, 1, 0);
    addVec(0, 0, 1, 3, 3, 2, 1, 1);
    addVec(1, 0, 0, 3, 3, 1, 1, 0);
    addVec(1, 0, 0, 0, 0, 0, 1, 1);
    addDrain(0, 0, 0, 5);

    // Config inputs change after the latch; the run keeps the latched values.
    cfgTotal = 2; cfgWork = 5; cfgRest = 3;
    addVec(0, 1, 0, 1, 1, 5, 1, 1);
    cfgTotal = 1; cfgWork = 9;
    addVec(0, 0, 0, 1, 1, 5, 1, 0);
    addVec(0, 0, 1, 2, 1, 3, 1, 1);
    addVec(0, 0, 1, 1, 2, 5, 1, 1);
    addVec(1, 0, 0, 1, 2, 4, 1, 0);
    addVec(0, 0, 1, 3, 2, 2, 1, 1);
    addVec(0, 1, 0, 0, 0, 0, 1, 1);
    addDrain(0, 0, 0, 6);

    rst = 1'b1; tick = 1'b0; start = 1'b0; skip = 1'b0;
    total = '0; work = '0; rest = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 2'd0, 9'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset pulse in the middle of REST clears everything without waiting for a clock edge.
    hv = '{tick: 1'b0, start: 1'b1, skip: 1'b0, total: 9'd2, work: 8'd5, rest: 8'd3,
           eState: 2'd1, eEx: 9'd1, eCd: 8'd5, eBuzz: 1'b1, ePc: 1'b1};
    applyStimulus("rstSeqStart", hv);
    hv.start = 1'b0; hv.skip = 1'b1;
    hv.eState = 2'd2; hv.eCd = 8'd3;
    applyStimulus("rstSeqSkip", hv);
    hv.skip = 1'b0; hv.tick = 1'b1;
    hv.eCd = 8'd2; hv.ePc = 1'b0;
    applyStimulus("rstSeqTick", hv);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("resetMidRest", 2'd0, 9'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    tick = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyIdle("postReset0", 0, 0, 0, 0, 0);
    applyIdle("postReset1", 0, 0, 0, 0, 0);
    applyIdle("postReset2", 0, 0, 0, 0, 0);
    hv = '{tick: 1'b0, start: 1'b1, skip: 1'b0, total: 9'd2, work: 8'd5, rest: 8'd3,
           eState: 2'd1, eEx: 9'd1, eCd: 8'd5, eBuzz: 1'b1, ePc: 1'b1};
    applyStimulus("restartAfterReset", hv);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
